// File: rtl/mfp_perf_counters_if.sv
// mfp_perf_counters_if: AHB-Lite slave bus bundle for the performance counter block.
interface mfp_perf_counters_if;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    modport master (output HSEL, HADDR, HTRANS, HWRITE, HWDATA, input HRDATA, HREADYOUT, HRESP);
    modport slave (input HSEL, HADDR, HTRANS, HWRITE, HWDATA, output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/mfp_perf_counters.sv
// mfp_perf_counters: AHB-Lite mapped event counters with snapshot, clear, overflow and interrupt.
module mfp_perf_counters #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int N_EV  = 8
) (
    input  logic                HCLK,
    input  logic                SI_Reset,
    mfp_perf_counters_if.slave  ahb,
    input  logic [N_EV-1:0]     PM_Event,
    output logic                PC_Irq
);
    localparam int EVSEL_W = $clog2(N_EV);
    logic                r_dp_valid, r_dp_write;
    logic [5:0]          r_dp_addr;
    logic                r_gen, r_frz, r_irq;
    logic [N_CH-1:0]     r_ovf, r_imask, r_en;
    logic [EVSEL_W-1:0]  r_sel [N_CH];
    logic [CNT_W-1:0]    r_cnt [N_CH];
    logic [CNT_W-1:0]    r_snp [N_CH];
    logic                w_wr, w_wr_ctrl, w_wr_ovf, w_wr_imask, w_snap, w_clr;
    logic [N_CH-1:0]     w_wr_sel, w_wr_cnt, w_ev, w_ovf_set;
    logic [CNT_W-1:0]    w_cnt_inc [N_CH];
    logic [31:0]         w_rdata;
    assign w_wr       = r_dp_valid & r_dp_write;
    assign w_wr_ctrl  = w_wr & (r_dp_addr == 6'd0);
    assign w_wr_ovf   = w_wr & (r_dp_addr == 6'd1);
    assign w_wr_imask = w_wr & (r_dp_addr == 6'd2);
    assign w_snap     = w_wr_ctrl & ahb.HWDATA[2];
    assign w_clr      = w_wr_ctrl & ahb.HWDATA[3];
    // Selector values at or beyond N_EV count a constant-zero event.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_wr_sel[i]  = w_wr & (r_dp_addr == 6'(8 + 2 * i));
            w_wr_cnt[i]  = w_wr & (r_dp_addr == 6'(9 + 2 * i));
            w_ev[i]      = r_gen & r_en[i] & ({1'b0, r_sel[i]} < (EVSEL_W + 1)'(N_EV)) & PM_Event[r_sel[i]];
            w_ovf_set[i] = w_ev[i] & (&r_cnt[i]) & ~w_wr_cnt[i];
            w_cnt_inc[i] = (w_ev[i] & ~(r_frz & (&r_cnt[i]))) ? r_cnt[i] + CNT_W'(1) : r_cnt[i];
        end
    end
    always_comb begin
        w_rdata = '0;
        if (r_dp_valid & ~r_dp_write) begin
            if (r_dp_addr == 6'd0) w_rdata = {30'd0, r_frz, r_gen};
            if (r_dp_addr == 6'd1) w_rdata[N_CH-1:0] = r_ovf;
            if (r_dp_addr == 6'd2) w_rdata[N_CH-1:0] = r_imask;
            for (int i = 0; i < N_CH; i++) begin
                if (r_dp_addr == 6'(8 + 2 * i)) w_rdata = {r_en[i], {(31 - EVSEL_W){1'b0}}, r_sel[i]};
                if (r_dp_addr == 6'(9 + 2 * i)) w_rdata = 32'(r_cnt[i]);
                if (r_dp_addr == 6'(32 + i)) w_rdata = 32'(r_snp[i]);
            end
        end
    end
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
            r_gen      <= 1'b0;
            r_frz      <= 1'b0;
            r_irq      <= 1'b0;
            r_ovf      <= '0;
            r_imask    <= '0;
            r_en       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_sel[i] <= '0;
                r_cnt[i] <= '0;
                r_snp[i] <= '0;
            end
        end else begin
            r_dp_valid <= ahb.HSEL & ahb.HTRANS[1];
            r_dp_write <= ahb.HWRITE;
            r_dp_addr  <= ahb.HADDR[7:2];
            r_irq      <= |(r_ovf & r_imask);
            if (w_wr_ctrl) {r_frz, r_gen} <= ahb.HWDATA[1:0];
            if (w_wr_imask) r_imask <= ahb.HWDATA[N_CH-1:0];
            // A fresh overflow beats a same-edge write-1-to-clear; CLR beats both.
            r_ovf <= w_clr ? '0 : (r_ovf & ~(w_wr_ovf ? ahb.HWDATA[N_CH-1:0] : '0)) | w_ovf_set;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_clr ? '0 : w_wr_cnt[i] ? ahb.HWDATA[CNT_W-1:0] : w_cnt_inc[i];
                if (w_snap) r_snp[i] <= w_cnt_inc[i];
                if (w_wr_sel[i]) begin
                    r_sel[i] <= ahb.HWDATA[EVSEL_W-1:0];
                    r_en[i]  <= ahb.HWDATA[31];
                end
            end
        end
    end
    assign ahb.HRDATA    = w_rdata;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign PC_Irq        = r_irq;
endmodule

// File: tb/tb_mfp_perf_counters.sv
// tb_mfp_perf_counters: directed bench for the performance counters (8-bit counters, 4 channels).
module tb_mfp_perf_counters;
    logic       HCLK = 1'b0;
    logic       SI_Reset = 1'b1;
    logic [7:0] PM_Event = '0;
    logic       PC_Irq;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [31:0] rdv;
    mfp_perf_counters_if bus();
    mfp_perf_counters #(.N_CH(4), .CNT_W(8), .N_EV(8)) dut (
        .HCLK(HCLK), .SI_Reset(SI_Reset), .ahb(bus), .PM_Event(PM_Event), .PC_Irq(PC_Irq)
    );
    always #5 HCLK = ~HCLK;
    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
    } vec_t;
    vec_t tv [22];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask
    task automatic aph(input logic w, input logic [7:0] a, input logic [31:0] dprev);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HADDR = a; bus.HWDATA = dprev;
    endtask
    task automatic dph(input logic [31:0] d);
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        aph(1'b1, a, '0);
        dph(d);
    endtask
    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        aph(1'b0, a, '0);
        dph('0);
        #1 chk(nm, bus.HRDATA, exp);
    endtask
    task automatic do_reset();
        @(negedge HCLK);
        SI_Reset = 1'b1;
        repeat (2) @(negedge HCLK);
        SI_Reset = 1'b0;
    endtask
    initial begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
        tv[0]  = '{1'b0, 8'h00, 32'h0};
        tv[1]  = '{1'b0, 8'h04, 32'h0};
        tv[2]  = '{1'b0, 8'h08, 32'h0};
        tv[3]  = '{1'b0, 8'h20, 32'h0};
        tv[4]  = '{1'b0, 8'h84, 32'h0};
        tv[5]  = '{1'b1, 8'h08, 32'hFFFF_FFFF};
        tv[6]  = '{1'b0, 8'h08, 32'h0000_000F};
        tv[7]  = '{1'b1, 8'h00, 32'h0000_000F};
        tv[8]  = '{1'b0, 8'h00, 32'h0000_0003};
        tv[9]  = '{1'b1, 8'h28, 32'hFFFF_FFFF};
        tv[10] = '{1'b0, 8'h28, 32'h8000_0007};
        tv[11] = '{1'b1, 8'h34, 32'h1234_5678};
        tv[12] = '{1'b0, 8'h34, 32'h0000_0078};
        tv[13] = '{1'b1, 8'h80, 32'h0000_00AB};
        tv[14] = '{1'b0, 8'h80, 32'h0};
        tv[15] = '{1'b1, 8'h40, 32'h8000_0001};
        tv[16] = '{1'b0, 8'h40, 32'h0};
        tv[17] = '{1'b0, 8'h0C, 32'h0};
        tv[18] = '{1'b1, 8'h00, 32'h0};
        tv[19] = '{1'b1, 8'h08, 32'h0};
        tv[20] = '{1'b1, 8'h28, 32'h0};
        tv[21] = '{1'b0, 8'h00, 32'h0};
        repeat (2) @(negedge HCLK);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_irq", 32'(PC_Irq), 32'h0);
        SI_Reset = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (tv[k].wr) wr(tv[k].a, tv[k].d);
            else rd_chk($sformatf("tbl[%0d]@%02h", k, tv[k].a), tv[k].a, tv[k].d);
        end
        // Basic counting on event 2.
        do_reset();
        wr(8'h20, 32'h8000_0002);
        wr(8'h00, 32'h1);
        @(negedge HCLK) PM_Event = 8'h04;
        repeat (10) @(negedge HCLK);
        PM_Event = '0;
        rd_chk("cnt0_10", 8'h24, 32'd10);
        rd_chk("cnt1_0", 8'h2C, 32'd0);
        rd_chk("cnt2_0", 8'h34, 32'd0);
        rd_chk("cnt3_0", 8'h3C, 32'd0);
        // Wrap with overflow and interrupt.
        wr(8'h08, 32'h1);
        wr(8'h24, 32'hFE);
        @(negedge HCLK) PM_Event = 8'h04;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("irq_lag", 32'(PC_Irq), 32'h0);
        @(negedge HCLK) PM_Event = '0;
        chk("irq_set", 32'(PC_Irq), 32'h1);
        rd_chk("wrap_cnt", 8'h24, 32'h01);
        rd_chk("wrap_ovf", 8'h04, 32'h1);
        // Saturation, then W1C racing a saturating event.
        wr(8'h00, 32'h3);
        wr(8'h04, 32'h1);
        wr(8'h24, 32'hFE);
        @(negedge HCLK) PM_Event = 8'h04;
        repeat (3) @(negedge HCLK);
        PM_Event = '0;
        rd_chk("sat_cnt", 8'h24, 32'hFF);
        rd_chk("sat_ovf", 8'h04, 32'h1);
        aph(1'b1, 8'h04, '0);
        dph(32'h1);
        PM_Event = 8'h04;
        @(negedge HCLK) PM_Event = '0;
        rd_chk("ovf_set_wins", 8'h04, 32'h1);
        wr(8'h04, 32'h1);
        rd_chk("ovf_w1c", 8'h04, 32'h0);
        // Snapshot including the same-edge increment, then clear.
        wr(8'h00, 32'h1);
        @(negedge HCLK) PM_Event = 8'h04;
        @(negedge HCLK);
        aph(1'b1, 8'h24, '0);
        aph(1'b1, 8'h00, 32'h20);
        dph(32'h5);
        repeat (3) @(negedge HCLK);
        PM_Event = '0;
        rd_chk("snap_cnt", 8'h24, 32'h23);
        rd_chk("snap_val", 8'h80, 32'h21);
        rd_chk("pre_clr_ovf", 8'h04, 32'h1);
        wr(8'h00, 32'h9);
        rd_chk("clr_cnt", 8'h24, 32'h0);
        rd_chk("clr_ovf", 8'h04, 32'h0);
        rd_chk("clr_snp", 8'h80, 32'h21);
        rd_chk("clr_ctrl", 8'h00, 32'h1);
        chk("clr_irq", 32'(PC_Irq), 32'h0);
        // Reset in the middle of counting and of a transfer.
        wr(8'h24, 32'hFF);
        @(negedge HCLK) PM_Event = 8'h04;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_irq", 32'(PC_Irq), 32'h1);
        aph(1'b0, 8'h00, '0);
        aph(1'b1, 8'h24, '0);
        #1 chk("pre_rst_rd", bus.HRDATA, 32'h1);
        SI_Reset = 1'b1;
        #1 chk("rst_async_hrdata", bus.HRDATA, 32'h0);
        chk("rst_async_irq", 32'(PC_Irq), 32'h0);
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = 32'h55;
        repeat (2) @(negedge HCLK);
        SI_Reset = 1'b0;
        @(negedge HCLK) PM_Event = '0;
        rd_chk("rst_cnt0", 8'h24, 32'h0);
        rd_chk("rst_sel0", 8'h20, 32'h0);
        rd_chk("rst_ctrl", 8'h00, 32'h0);
        rd_chk("rst_ovf", 8'h04, 32'h0);
        rd_chk("rd_60", 8'h60, 32'h0);
        chk("hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("hresp", 32'(bus.HRESP), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mfp_perf_counters.md
MFP_PERF_COUNTERS -- requirements
Module: mfp_perf_counters

Interface
REQ-001 Parameter N_CH, default 4: number of counter channels, 1..8.
REQ-002 Parameter CNT_W, default 32: counter width, 8..32.
REQ-003 Parameter N_EV, default 8: number of event inputs, 2..16; EVSEL_W = clog2(N_EV).
REQ-004 Port HCLK, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port SI_Reset, input, 1: asynchronous, active-high reset.
REQ-006 Port HSEL, input, 1: AHB-Lite slave select.
REQ-007 Port HADDR, input, 8: byte address within block; bits[1:0] ignored.
REQ-008 Port HTRANS, input, 2: transfer valid when HTRANS[1]=1.
REQ-009 Port HWRITE, input, 1: 1 = write.
REQ-010 Port HWDATA, input, 32: write data, sampled in data phase.
REQ-011 Port HRDATA, output, 32: read data, valid in data phase.
REQ-012 Port HREADYOUT, output, 1: constant 1, zero wait states.
REQ-013 Port HRESP, output, 1: constant 0, OKAY.
REQ-014 Port PM_Event, input, N_EV: level event strobes, synchronous to HCLK, e.g. instruction complete, D$ hit, D$ miss, run stages.
REQ-015 Port PC_Irq, output, 1: overflow interrupt, registered.

Function
REQ-016 Address phase: HSEL & HTRANS[1] is captured with HADDR[7:2] and HWRITE into registers; data phase is the following cycle.
REQ-017 Register map (word offsets):
- 0x00 CTRL: [0] GEN, global enable; [1] FRZ, saturate instead of wrap; [2] SNAP, write-1 pulse; [3] CLR, write-1 pulse. Bits [3:2] read 0.
- 0x04 OVF: [N_CH-1:0] sticky overflow, write-1-to-clear.
- 0x08 IMASK: [N_CH-1:0] interrupt mask.
- 0x20+8i SELi: [EVSEL_W-1:0] event index; [31] channel enable ENi.
- 0x24+8i CNTi: live counter, zero-extended; writable.
- 0x80+4i SNPi: snapshot, read-only.
- Unmapped or i>=N_CH: reads 0, writes ignored.
REQ-018 Writes take effect at the end of the data-phase cycle; reads return register state at the start of the data-phase cycle.
REQ-019 Channel i increments by 1 on a clock edge where GEN=1, ENi=1 and PM_Event[SELi]=1. The new value is readable from the next cycle. SELi>=N_EV selects constant 0.
REQ-020 Wrap, FRZ=0: all-ones+1 gives 0 and sets OVF[i] in the same edge.
REQ-021 Saturate, FRZ=1: an increment at all-ones holds all-ones and sets OVF[i].
REQ-022 SNAP=1 write copies all CNTi, including any increment occurring on that same edge, into SNPi atomically.
REQ-023 CLR=1 write zeroes all CNTi and OVF. It overrides a same-edge increment or overflow set. SNPi, SEL, IMASK and CTRL[1:0] are unchanged.
REQ-024 CNTi write overrides a same-edge increment; OVF is not set by that increment.
REQ-025 OVF W1C on the same edge as a new overflow of that bit: the set wins.
REQ-026 PC_Irq is registered |(OVF & IMASK), one cycle after the OVF/IMASK change.
REQ-027 Register writes use full-word semantics regardless of HSIZE; HSIZE is not a port.

Reset
REQ-028 SI_Reset=1 asynchronously clears all CNTi, SNPi, SELi, ENi, OVF, IMASK, CTRL and the address-phase registers; PC_Irq=0, HRDATA=0.
REQ-029 A transfer whose address phase precedes the reset deassertion is discarded; the first valid address phase is on the first edge after deassertion.
REQ-030 Events during reset are not counted.

Verification
REQ-031 Reset, then write SEL0=0x80000002 and CTRL=1, hold PM_Event[2]=1 for 10 cycles -> CNT0 reads 10, other CNTs 0.
REQ-032 CNTW=8, FRZ=0, CNT0 written 0xFE, 3 events -> CNT0=0x01, OVF=0x1; with IMASK=1, PC_Irq=1 one cycle after OVF sets.
REQ-033 Same setup with FRZ=1 -> CNT0=0xFF, OVF=0x1; W1C of OVF coincident with another saturating event -> OVF stays 0x1.
REQ-034 Continuous event, write CTRL=0x5 at count 0x20 -> SNP0=0x21 (includes same-edge increment), CNT0 continues counting; then CTRL=0x9 -> CNT0=0, OVF=0, SNP0 still 0x21.
REQ-035 Assert SI_Reset mid-count and mid-transfer -> all outputs 0 immediately, CNT0=0 after release, pending write lost; reads of 0x60 with N_CH=4 -> 0.
